// File: rtl/instr_decode_pipe_pkg.sv
`default_nettype none
// instr_decode_pipe_pkg: condition codes, opcode constants, class codes and
// the decode-bundle layout shared by the decode pipe and its users.
package instr_decode_pipe_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_UN = 4'hF
    } cond_e;

    localparam logic [3:0]  OP_MOV_LAS = 4'hD;
    localparam logic [3:0]  OP_ADDS    = 4'h4;
    localparam logic [3:0]  OP_ADCS    = 4'h5;
    localparam logic [23:0] OP_BX      = 24'h12FFF1;
    localparam logic [27:0] OP_ERET    = 28'h160006E;

    typedef enum logic [4:0] {
        NO_INST = 5'd0,
        MOV_LAS = 5'd1,
        B       = 5'd2,
        BX      = 5'd3,
        ERET    = 5'd4,
        ADD     = 5'd5,
        ADC     = 5'd6
    } iclass_e;

    typedef struct packed {
        iclass_e     instr;
        logic        skip;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [11:0] imm12;
        logic [4:0]  imm5;
        logic [1:0]  stype;
        logic        imm;
        logic        s;
        logic        link;
        logic [23:0] br_offset24;
        logic        write_rd;
        logic        br_en;
    } dec_bundle_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic n,
                                       input logic z, input logic c, input logic v);
        logic pass;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode_pipe_instr_queue.sv
`default_nettype none
// instr_queue: parametrised circular FIFO with push, pop, flush and occupancy.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !flush && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/instr_decode_pipe.sv
`default_nettype none
// instr_decode_pipe: queued A32 decoder with condition evaluation, flag-hazard
// stall and flush, producing a registered decode bundle for execute.
module instr_decode_pipe
    import instr_decode_pipe_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int PC_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_valid,
    input  logic [31:0]               fetch_instr,
    input  logic [PC_W-1:0]           fetch_pc,
    output logic                      fetch_ready,
    input  logic                      flush,
    input  logic                      n,
    input  logic                      z,
    input  logic                      c,
    input  logic                      v,
    input  logic                      flags_busy,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [4:0]                dec_instr,
    output logic                      dec_skip,
    output logic [3:0]                dec_rn,
    output logic [3:0]                dec_rd,
    output logic [3:0]                dec_rm,
    output logic [3:0]                dec_rs,
    output logic [11:0]               dec_imm12,
    output logic [4:0]                dec_imm5,
    output logic [1:0]                dec_stype,
    output logic                      dec_imm,
    output logic                      dec_S,
    output logic                      dec_link,
    output logic [23:0]               dec_br_offset24,
    output logic                      dec_write_rd,
    output logic                      dec_br_en,
    output logic [PC_W-1:0]           dec_pc,
    output logic [$clog2(IQ_DEPTH):0] iq_count
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    logic [31:0]     head_instr;
    logic [PC_W-1:0] head_pc;
    logic            push;
    logic            load;
    logic            stall;
    iclass_e         cls;
    dec_bundle_t     fields;
    dec_bundle_t     bundle;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;

    assign fetch_ready = (iq_count != CNT_W'(IQ_DEPTH));
    assign push        = fetch_valid && fetch_ready && !flush;

    // Conditional heads wait until no in-flight op can still change the flags.
    assign stall = !(head_instr[31:28] inside {COND_AL, COND_UN}) &&
                   (flags_busy || (valid_q && bundle.s));
    assign load  = (!valid_q || dec_ready) && (iq_count != '0) && !stall && !flush;

    instr_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (32 + PC_W)
    ) u_iq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .flush (flush),
        .wdata ({fetch_instr, fetch_pc}),
        .rdata ({head_instr, head_pc}),
        .count (iq_count)
    );

    always_comb begin
        cls    = NO_INST;
        fields = '0;
        if (head_instr[27:26] == 2'b00 && head_instr[24:21] == OP_MOV_LAS) cls = MOV_LAS;
        else if (head_instr[27:25] == 3'b101)                                 cls = B;
        else if (head_instr[27:4] == OP_BX)                                   cls = BX;
        else if (head_instr[27:0] == OP_ERET)                                 cls = ERET;
        else if (head_instr[27:26] == 2'b00 && head_instr[24:21] == OP_ADDS)  cls = ADD;
        else if (head_instr[27:26] == 2'b00 && head_instr[24:21] == OP_ADCS)  cls = ADC;
        fields.instr = cls;
        case (cls)
            MOV_LAS, ADD, ADC: begin
                if (cls != MOV_LAS) fields.rn = head_instr[19:16];
                fields.rd       = head_instr[15:12];
                fields.s        = head_instr[20];
                fields.imm      = head_instr[25];
                fields.write_rd = 1'b1;
                if (head_instr[25]) begin
                    fields.imm12 = head_instr[11:0];
                end else begin
                    fields.rm    = head_instr[3:0];
                    fields.stype = head_instr[6:5];
                    if (head_instr[4]) fields.rs   = head_instr[11:8];
                    else               fields.imm5 = head_instr[11:7];
                end
            end
            B: begin
                fields.link        = head_instr[24];
                fields.br_offset24 = head_instr[23:0];
                fields.br_en       = 1'b1;
            end
            BX: begin
                fields.rm    = head_instr[3:0];
                fields.br_en = 1'b1;
            end
            ERET:    fields.br_en = 1'b1;
            default: ;
        endcase
        fields.skip = (cls == NO_INST) || !cond_pass(head_instr[31:28], n, z, c, v);
        if (fields.skip) begin
            fields.write_rd = 1'b0;
            fields.br_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            bundle  <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            bundle  <= fields;
            pc_q    <= head_pc;
        end else if (dec_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign dec_valid       = valid_q;
    assign dec_instr       = bundle.instr;
    assign dec_skip        = bundle.skip;
    assign dec_rn          = bundle.rn;
    assign dec_rd          = bundle.rd;
    assign dec_rm          = bundle.rm;
    assign dec_rs          = bundle.rs;
    assign dec_imm12       = bundle.imm12;
    assign dec_imm5        = bundle.imm5;
    assign dec_stype       = bundle.stype;
    assign dec_imm         = bundle.imm;
    assign dec_S           = bundle.s;
    assign dec_link        = bundle.link;
    assign dec_br_offset24 = bundle.br_offset24;
    assign dec_write_rd    = bundle.write_rd;
    assign dec_br_en       = bundle.br_en;
    assign dec_pc          = pc_q;

endmodule
`default_nettype wire
